// File: rtl/alu_ctrl.sv
// alu_ctrl: IDLE/EXEC/WB issue controller driving an external combinational ALU.
// Optional ALU_CTRL_CMP_FLAG_EN: CMP sets flag_eq instead of writing a register.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic       instr_dst,
  input  logic       instr_bsel,
  input  logic [7:0] instr_lit,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_s,
  input  logic [7:0] alu_out,
  output logic [7:0] reg_a,
  output logic [7:0] reg_b,
  output logic       busy,
  output logic       done
`ifdef ALU_CTRL_CMP_FLAG_EN
  ,
  output logic       flag_eq
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [3:0] op_q;
  logic       dst_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] res_q;
  logic       xfer;
  logic       wr;

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == WB);
  assign xfer        = instr_valid && instr_ready;

  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_s = op_q;

`ifdef ALU_CTRL_CMP_FLAG_EN
  assign wr = (state == WB) && (op_q != 4'hF);
`else
  assign wr = (state == WB);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (xfer) nxt = EXEC;
      EXEC:    nxt = WB;
      WB:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // operands are sampled at transfer and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      dst_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      if (xfer) begin
        op_q  <= instr_op;
        dst_q <= instr_dst;
        a_q   <= reg_a;
        b_q   <= instr_bsel ? instr_lit : reg_b;
      end
      if (state == EXEC) res_q <= alu_out;
      if (wr && !dst_q)  reg_a <= res_q;
      if (wr && dst_q)   reg_b <= res_q;
    end
  end

`ifdef ALU_CTRL_CMP_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flag_eq <= 1'b0;
    else if (state == WB && op_q == 4'hF)
      flag_eq <= res_q[0];
  end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: random + directed stimulus, queue scoreboard, behavioural ALU.
// Honours ALU_CTRL_CMP_FLAG_EN the same way as the design.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = '0;
  logic       instr_dst = 1'b0;
  logic       instr_bsel = 1'b0;
  logic [7:0] instr_lit = '0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_s;
  logic [7:0] alu_out;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic       busy;
  logic       done;
`ifdef ALU_CTRL_CMP_FLAG_EN
  logic       flag_eq;
`endif

  alu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_dst  (instr_dst),
    .instr_bsel (instr_bsel),
    .instr_lit  (instr_lit),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_out    (alu_out),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .busy       (busy),
    .done       (done)
`ifdef ALU_CTRL_CMP_FLAG_EN
    ,
    .flag_eq    (flag_eq)
`endif
  );

  always #5 clk = ~clk;

  // the external ALU
  always_comb begin
    alu_out = 8'h00;
    case (alu_s)
      4'h0: alu_out = alu_a + alu_b;
      4'h1: alu_out = alu_a - alu_b;
      4'h2: alu_out = alu_b;
      4'h9: alu_out = alu_b;
      4'hF: alu_out = (alu_a == alu_b) ? 8'h01 : 8'h00;
      default: alu_out = 8'h00;
    endcase
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       f;
    int         tedge;
  } exp_t;

  exp_t q[$];
  exp_t pe;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   pend = 0;
  int   last_tedge = -100;
  bit   chain = 0;

  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic       m_f = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cur_flag();
`ifdef ALU_CTRL_CMP_FLAG_EN
    return flag_eq;
`else
    return 1'b0;
`endif
  endfunction

  // monitor: pops on every done pulse, checks the writeback one cycle later
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
    end else if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        pe = q.pop_front();
        chk("done_latency", cyc - pe.tedge, 1);
        chk("alu_s_hold", {28'd0, alu_s}, {28'd0, pe.op});
        chk("busy_wb", {31'd0, busy}, 32'd1);
        chk("ready_wb", {31'd0, instr_ready}, 32'd0);
        pend = 1;
      end
    end else if (pend) begin
      chk("reg_a", {24'd0, reg_a}, {24'd0, pe.a});
      chk("reg_b", {24'd0, reg_b}, {24'd0, pe.b});
      chk("flag_eq", {31'd0, cur_flag()}, {31'd0, pe.f});
      chk("ready_after", {31'd0, instr_ready}, 32'd1);
      pend = 0;
    end
  end

  task automatic issue(input logic [3:0] op, input logic dst,
                       input logic bsel, input logic [7:0] lit,
                       input bit hold);
    int waitc;
    int a;
    int b;
    int r;
    exp_t e;
    waitc = 0;
    instr_valid = 1'b1;
    instr_op = op;
    instr_dst = dst;
    instr_bsel = bsel;
    instr_lit = lit;
    while (!instr_ready) begin
      @(negedge clk);
      waitc++;
      if (waitc > 10) begin
        chk("ready_timeout", 32'd0, 32'd1);
        instr_valid = 1'b0;
        chain = 0;
        return;
      end
    end
    a = m_a;
    b = bsel ? lit : m_b;
    case (op)
      4'h0:    r = (a + b) % 256;
      4'h1:    r = (a - b + 256) % 256;
      4'h2,
      4'h9:    r = b;
      4'hF:    r = (a == b) ? 1 : 0;
      default: r = 0;
    endcase
`ifdef ALU_CTRL_CMP_FLAG_EN
    if (op == 4'hF) m_f = r[0];
    else if (dst) m_b = r[7:0];
    else m_a = r[7:0];
`else
    if (dst) m_b = r[7:0];
    else m_a = r[7:0];
`endif
    @(negedge clk);
    e.op = op;
    e.a = m_a;
    e.b = m_b;
    e.f = m_f;
    e.tedge = cyc;
    q.push_back(e);
    if (chain) chk("burst_spacing", cyc - last_tedge, 3);
    last_tedge = cyc;
    chain = hold;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || pend || !instr_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [3:0] ops [6];
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2;
    ops[3] = 4'h9; ops[4] = 4'hF; ops[5] = 4'h5;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_regs", {reg_a, reg_b}, 32'd0);
    chk("rst_alu", {alu_a, alu_b, 4'd0, alu_s}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flag", {31'd0, cur_flag()}, 32'd0);

    issue(4'h9, 1'b0, 1'b1, 8'h05, 0);
    drain();
    chk("mov_a5", {reg_a, reg_b}, 32'h0500);

    issue(4'h9, 1'b0, 1'b1, 8'hFF, 0);
    issue(4'h9, 1'b1, 1'b1, 8'h02, 0);
    issue(4'h0, 1'b0, 1'b0, 8'h00, 0);
    drain();
    chk("add_wrap", {24'd0, reg_a}, 32'h01);
    issue(4'h1, 1'b0, 1'b1, 8'h03, 0);
    drain();
    chk("sub_wrap", {24'd0, reg_a}, 32'hFE);

    issue(4'h9, 1'b0, 1'b1, 8'h07, 0);
    issue(4'hF, 1'b1, 1'b1, 8'h07, 0);
    drain();
`ifdef ALU_CTRL_CMP_FLAG_EN
    chk("cmp_eq", {reg_a, reg_b, 7'd0, flag_eq}, 32'h07020001);
`else
    chk("cmp_eq", {16'd0, reg_a, reg_b}, 32'h0701);
`endif
    issue(4'hF, 1'b1, 1'b1, 8'h08, 0);
    drain();
`ifdef ALU_CTRL_CMP_FLAG_EN
    chk("cmp_ne", {reg_a, reg_b, 7'd0, flag_eq}, 32'h07020000);
`else
    chk("cmp_ne", {16'd0, reg_a, reg_b}, 32'h0700);
`endif

    issue(4'h5, 1'b0, 1'b1, 8'h33, 0);
    chk("unlisted_alu_s", {28'd0, alu_s}, 32'h5);
    drain();
    chk("unlisted_zero", {24'd0, reg_a}, 32'h00);

    for (int i = 0; i < 4; i++)
      issue(4'h9, i[0], 1'b1, 8'h10 + 8'(i), i < 3);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(ops[$urandom_range(0, 5)], 1'($urandom), 1'($urandom),
            8'($urandom), 1'($urandom));
      if (!chain) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    instr_valid = 1'b0;
    chain = 0;
    drain();

    issue(4'h0, 1'b0, 1'b1, 8'h11, 0);
    rst_n = 1'b0;
    q.delete();
    m_a = 8'h00;
    m_b = 8'h00;
    m_f = 1'b0;
    @(negedge clk);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_regs", {reg_a, reg_b}, 32'd0);
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_nodone", {31'd0, done}, 32'd0);
    chk("abort_flag", {31'd0, cur_flag()}, 32'd0);

    issue(4'h9, 1'b1, 1'b1, 8'hA5, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
